// File: rtl/store_buffer.sv
// Store buffer: aligns decoded stores to word byte lanes, queues them in a FIFO,
// and drains them to dmem over a req/ack handshake.
// Optional store-to-load forwarding is enabled by defining STB_FWD_EN.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  input  logic [3:0]                 st_wr_en,
  output logic                       misalign_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       mem_req,
  input  logic                       mem_ack,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_be,
  input  logic [31:0]                ld_addr,
  output logic                       ld_hit,
  output logic [31:0]                ld_data,
  output logic                       ld_stall
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e      state_q, state_d;
  cnt_t        count_q, count_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  logic        misalign_err_q, misalign_err_d;

  logic [29:0] addr_q  [DEPTH];
  logic [31:0] wdata_q [DEPTH];
  logic [3:0]  be_q    [DEPTH];

  logic [1:0]  off;
  logic [7:0]  mask_wide;
  logic        misaligned;
  logic        accept;
  logic        push;
  logic        pop;
  logic [3:0]  al_be;
  logic [31:0] al_data;

  // Lane alignment; any mask bit shifted past lane 3 marks the store as misaligned.
  always_comb begin
    off        = st_addr[1:0];
    mask_wide  = {4'b0000, st_wr_en} << off;
    misaligned = |mask_wide[7:4];
    al_be      = mask_wide[3:0];
    al_data    = st_data << {off, 3'b000};
    st_ready   = !rst && (count_q < cnt_t'(DEPTH));
    accept     = st_valid && st_ready;
    push       = accept && (st_wr_en != 4'b0000) && !misaligned;
    pop        = (state_q == StReq) && mem_ack;
  end

  // Pointer, occupancy and error-pulse next state.
  always_comb begin
    wr_ptr_d       = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d       = pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    count_d        = count_q;
    if (push && !pop) begin
      count_d = count_q + cnt_t'(1);
    end else if (!push && pop) begin
      count_d = count_q - cnt_t'(1);
    end
    misalign_err_d = accept && misaligned;
  end

  // Drain FSM next state and dmem outputs; outputs are zero while idle.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    unique case (state_q)
      StIdle: begin
        // Looking at the incoming push gives mem_req one cycle after acceptance.
        if (count_q != cnt_t'(0) || push) begin
          state_d = StReq;
        end
      end
      StReq: begin
        mem_req   = 1'b1;
        mem_addr  = {addr_q[rd_ptr_q], 2'b00};
        mem_wdata = wdata_q[rd_ptr_q];
        mem_be    = be_q[rd_ptr_q];
        if (pop && count_d == cnt_t'(0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q]  <= st_addr[31:2];
      wdata_q[wr_ptr_q] <= al_data;
      be_q[wr_ptr_q]    <= al_be;
    end
  end

  assign count        = count_q;
  assign empty        = (count_q == cnt_t'(0));
  assign misalign_err = misalign_err_q;

`ifdef STB_FWD_EN
  logic        fwd_found;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_be;
  ptr_t        fwd_idx;
  logic [1:0]  unused_ld_lo;

  assign unused_ld_lo = ld_addr[1:0];

  // Scan oldest to youngest so the youngest matching entry overrides earlier ones.
  always_comb begin
    fwd_found = 1'b0;
    fwd_data  = 32'h0;
    fwd_be    = 4'h0;
    fwd_idx   = rd_ptr_q;
    for (int k = 0; k < int'(DEPTH); k++) begin
      fwd_idx = rd_ptr_q + ptr_t'(k);
      if (k < int'(count_q) && addr_q[fwd_idx] == ld_addr[31:2]) begin
        fwd_found = 1'b1;
        fwd_data  = wdata_q[fwd_idx];
        fwd_be    = be_q[fwd_idx];
      end
    end
    ld_hit   = fwd_found && (fwd_be == 4'hf);
    ld_stall = fwd_found && (fwd_be != 4'hf);
    ld_data  = ld_hit ? fwd_data : 32'h0;
  end
`else
  logic unused_ld;

  assign unused_ld = ^ld_addr;
  assign ld_hit    = 1'b0;
  assign ld_stall  = 1'b0;
  assign ld_data   = 32'h0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4).
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_wr_en;
  logic        misalign_err;
  logic [2:0]  count;
  logic        empty;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_stall;

  int checks = 0;
  int failures = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_wr_en     (st_wr_en),
    .misalign_err (misalign_err),
    .count        (count),
    .empty        (empty),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .ld_addr      (ld_addr),
    .ld_hit       (ld_hit),
    .ld_data      (ld_data),
    .ld_stall     (ld_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] en);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_wr_en = en;
  endtask

  logic [31:0] exp_addr [5];
  logic [31:0] exp_data [5];

  initial begin
    rst      = 1'b1;
    mem_ack  = 1'b0;
    ld_addr  = 32'h0;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    step();
    step();
    check("rst_ready", {31'b0, st_ready}, 32'd0);
    check("rst_count", {29'b0, count}, 32'd0);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_be", {28'b0, mem_be}, 32'h0);
    check("rst_err", {31'b0, misalign_err}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'b0, st_ready}, 32'd1);

    // SB to 0x1003 with mem_ack already high: ack ignored while idle.
    mem_ack = 1'b1;
    drive(1'b1, 32'h1003, 32'h0000_00ab, 4'b0001);
    step();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("sb_req", {31'b0, mem_req}, 32'd1);
    check("sb_addr", mem_addr, 32'h1000);
    check("sb_be", {28'b0, mem_be}, 32'h8);
    check("sb_wdata", mem_wdata, 32'hab00_0000);
    check("sb_count", {29'b0, count}, 32'd1);
    step();
    check("sb_drained_req", {31'b0, mem_req}, 32'd0);
    check("sb_drained_empty", {31'b0, empty}, 32'd1);
    check("idle_addr_zero", mem_addr, 32'h0);
    mem_ack = 1'b0;

    // Misaligned SH: consumed, not queued, one-cycle error pulse.
    drive(1'b1, 32'h2003, 32'h1234, 4'b0011);
    step();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("mis_err", {31'b0, misalign_err}, 32'd1);
    check("mis_count", {29'b0, count}, 32'd0);
    check("mis_req", {31'b0, mem_req}, 32'd0);
    step();
    check("mis_err_clear", {31'b0, misalign_err}, 32'd0);

    // Misaligned SW at offset 2.
    drive(1'b1, 32'h2002, 32'h1234_5678, 4'b1111);
    step();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("mis_sw_err", {31'b0, misalign_err}, 32'd1);
    check("mis_sw_count", {29'b0, count}, 32'd0);

    // Empty mask: consumed silently.
    drive(1'b1, 32'h2000, 32'h1234, 4'b0000);
    step();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("none_err", {31'b0, misalign_err}, 32'd0);
    check("none_count", {29'b0, count}, 32'd0);

    // Fill with four SWs while dmem stalls.
    for (int i = 0; i < 5; i++) begin
      exp_addr[i] = 32'h100 + 32'(4 * i);
      exp_data[i] = 32'hd000_0000 + 32'(i);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, exp_addr[i], exp_data[i], 4'b1111);
      step();
    end
    drive(1'b1, exp_addr[4], exp_data[4], 4'b1111);
    #1;
    check("full_count", {29'b0, count}, 32'd4);
    check("full_ready", {31'b0, st_ready}, 32'd0);
    check("full_head", mem_addr, exp_addr[0]);
    step();
    check("held_count", {29'b0, count}, 32'd4);
    check("held_head_stable", mem_wdata, exp_data[0]);

    // Ack while full: no bypass, fifth store waits a cycle.
    mem_ack = 1'b1;
    #1;
    check("full_ack_ready", {31'b0, st_ready}, 32'd0);
    step();
    check("pop1_count", {29'b0, count}, 32'd3);
    check("pop1_head", mem_addr, exp_addr[1]);
    check("pop1_ready", {31'b0, st_ready}, 32'd1);
    step();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("pushpop_count", {29'b0, count}, 32'd3);
    for (int i = 2; i < 5; i++) begin
      check("drain_req", {31'b0, mem_req}, 32'd1);
      check("drain_addr", mem_addr, exp_addr[i]);
      check("drain_data", mem_wdata, exp_data[i]);
      check("drain_be", {28'b0, mem_be}, 32'hf);
      step();
    end
    check("drain_empty", {31'b0, empty}, 32'd1);
    check("drain_req_low", {31'b0, mem_req}, 32'd0);
    mem_ack = 1'b0;

    // Aligned SH/SB lane placement, then reset mid-drain with three entries.
    drive(1'b1, 32'h2002, 32'h0000_1234, 4'b0011);
    step();
    check("sh_be", {28'b0, mem_be}, 32'hc);
    check("sh_wdata", mem_wdata, 32'h1234_0000);
    check("sh_addr", mem_addr, 32'h2000);
    drive(1'b1, 32'h2001, 32'hffff_ffcd, 4'b0001);
    step();
    drive(1'b1, 32'h2008, 32'h5555_5555, 4'b1111);
    step();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("pre_rst_count", {29'b0, count}, 32'd3);
    // Forwarding path idles at zero unless the feature is built in.
`ifndef STB_FWD_EN
    ld_addr = 32'h2008;
    #1;
    check("nofwd_hit", {31'b0, ld_hit}, 32'd0);
    check("nofwd_stall", {31'b0, ld_stall}, 32'd0);
    check("nofwd_data", ld_data, 32'h0);
`endif
    rst = 1'b1;
    step();
    check("mid_rst_count", {29'b0, count}, 32'd0);
    check("mid_rst_req", {31'b0, mem_req}, 32'd0);
    check("mid_rst_empty", {31'b0, empty}, 32'd1);
    check("mid_rst_ready", {31'b0, st_ready}, 32'd0);
    rst = 1'b0;
    step();

`ifdef STB_FWD_EN
    drive(1'b1, 32'h3000, 32'h11, 4'b1111);
    step();
    drive(1'b1, 32'h3000, 32'h22, 4'b1111);
    step();
    drive(1'b1, 32'h3004, 32'hab, 4'b0001);
    step();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    ld_addr = 32'h3002;
    #1;
    check("fwd_hit", {31'b0, ld_hit}, 32'd1);
    check("fwd_data", ld_data, 32'h22);
    check("fwd_hit_stall", {31'b0, ld_stall}, 32'd0);
    ld_addr = 32'h3004;
    #1;
    check("fwd_stall", {31'b0, ld_stall}, 32'd1);
    check("fwd_stall_hit", {31'b0, ld_hit}, 32'd0);
    ld_addr = 32'h5000;
    #1;
    check("fwd_miss_hit", {31'b0, ld_hit}, 32'd0);
    check("fwd_miss_stall", {31'b0, ld_stall}, 32'd0);
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) step();
    mem_ack = 1'b0;
    check("fwd_drained", {31'b0, empty}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
